// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_pkg
//  Description : Shared constants and state encoding for the conv-1 max-pool
//                stage (2x2 window, stride 2, 28x28 maps in, 14x14 maps out).
//  Revision    : 1.0  initial release
// ============================================================================
package pool_pkg;

   localparam int IN_LANES  = 56;   // samples per fm_bram_1 word (two maps)
   localparam int OUT_LANES = 28;   // samples per fm_bram_2 word (two maps)
   localparam int OUT_ROWS  = 14;   // pooled rows per map
   localparam int WORDS_OUT = 42;   // pooled words per pass

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/pool_lane.sv
`default_nettype none
// ============================================================================
//  Module      : pool_lane
//  Description : Combinational signed max of one 2x2 window (two samples from
//                the even row, two from the odd row) with optional clamp of
//                negative results to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module pool_lane #(
   parameter int DATA_W = 16,
   parameter int RELU   = 1
) (
   input  logic signed [DATA_W-1:0] a0,
   input  logic signed [DATA_W-1:0] a1,
   input  logic signed [DATA_W-1:0] b0,
   input  logic signed [DATA_W-1:0] b1,
   output logic signed [DATA_W-1:0] y
);

   logic signed [DATA_W-1:0] w_max_a;
   logic signed [DATA_W-1:0] w_max_b;
   logic signed [DATA_W-1:0] w_max;

   // Max tree over the window; a max of in-range values cannot overflow.
   always_comb begin
      w_max_a = (a0 > a1) ? a0 : a1;
      w_max_b = (b0 > b1) ? b0 : b1;
      w_max   = (w_max_a > w_max_b) ? w_max_a : w_max_b;
      y       = w_max;
      if ((RELU != 0) && w_max[DATA_W-1]) begin
         y = '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pool_1.sv
`default_nettype none
// ============================================================================
//  Module      : pool_1
//  Description : 2x2 stride-2 max pool (optional ReLU) from fm_bram_1 (28x28,
//                six maps) into fm_bram_2 (14x14, six maps). One read pair
//                per cycle, one pooled word written per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module pool_1
   import pool_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ROWS_IN  = 28,
   parameter int PAIRS    = 3,
   parameter int READ_LAT = 1,
   parameter int RELU     = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          pool_1_en,
   output logic                          pool_1_finish,
   output logic                          busy,
   output logic                          fm_bram_1_ena,
   output logic                          fm_bram_1_enb,
   output logic [6:0]                    fm_bram_1_addra,
   output logic [6:0]                    fm_bram_1_addrb,
   input  logic [IN_LANES*DATA_W-1:0]    fm_bram_1_douta,
   input  logic [IN_LANES*DATA_W-1:0]    fm_bram_1_doutb,
   output logic                          fm_bram_2_we,
   output logic [5:0]                    fm_bram_2_addr,
   output logic [OUT_LANES*DATA_W-1:0]   fm_bram_2_din
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ISSUE = ISSUE;
   localparam logic [1:0] ST_DRAIN = DRAIN;
   localparam logic [1:0] ST_DONE  = DONE;

   localparam int         PAIR_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [5:0] LAST_WORD = 6'(WORDS_OUT - 1);
   localparam logic [3:0] LAST_ROW  = 4'(OUT_ROWS - 1);

   logic [1:0]                   r_state;
   logic                         r_en_q;
   logic                         r_ena;
   logic [6:0]                   r_addra;
   logic [6:0]                   r_addrb;
   logic [3:0]                   r_orow;
   logic [PAIR_W-1:0]            r_pair;
   logic [5:0]                   r_cnt;
   logic [READ_LAT-1:0]          r_vld;
   logic [5:0]                   r_vaddr [READ_LAT];
   logic                         r_we;
   logic [5:0]                   r_waddr;
   logic [OUT_LANES*DATA_W-1:0]  r_din;

   logic                         w_rise;
   logic                         w_abort;
   logic [3:0]                   w_orow_nxt;
   logic [PAIR_W-1:0]            w_pair_nxt;
   logic [OUT_LANES*DATA_W-1:0]  w_pooled;

   // Even-row word address of (pair, output row); the odd row is the next word.
   function automatic logic [6:0] rd_addr(input logic [PAIR_W-1:0] p, input logic [3:0] r);
      return 7'(p) * 7'(ROWS_IN) + {2'b00, r, 1'b0};
   endfunction

   assign w_rise  = pool_1_en & ~r_en_q;
   assign w_abort = ~pool_1_en & ((r_state == ST_ISSUE) | (r_state == ST_DRAIN));

   // Output-row counter wraps at the end of a map pair and steps the pair.
   always_comb begin
      w_orow_nxt = r_orow + 4'd1;
      w_pair_nxt = r_pair;
      if (r_orow == LAST_ROW) begin
         w_orow_nxt = 4'd0;
         w_pair_nxt = r_pair + PAIR_W'(1);
      end
   end

   // Registered copy of the enable for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_q <= 1'b0;
      end else begin
         r_en_q <= pool_1_en;
      end
   end

   // Control FSM and read-issue counters; read address/enable are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ena   <= 1'b0;
         r_addra <= 7'd0;
         r_addrb <= 7'd0;
         r_orow  <= 4'd0;
         r_pair  <= '0;
         r_cnt   <= 6'd0;
      end else if (w_abort) begin
         r_state <= ST_IDLE;
         r_ena   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_state <= ST_ISSUE;
                  r_ena   <= 1'b1;
                  r_addra <= 7'd0;
                  r_addrb <= 7'd1;
                  r_orow  <= 4'd0;
                  r_pair  <= '0;
                  r_cnt   <= 6'd0;
               end
            end
            ST_ISSUE: begin
               if (r_cnt == LAST_WORD) begin
                  r_state <= ST_DRAIN;
                  r_ena   <= 1'b0;
               end else begin
                  r_orow  <= w_orow_nxt;
                  r_pair  <= w_pair_nxt;
                  r_cnt   <= r_cnt + 6'd1;
                  r_addra <= rd_addr(w_pair_nxt, w_orow_nxt);
                  r_addrb <= rd_addr(w_pair_nxt, w_orow_nxt) + 7'd1;
               end
            end
            ST_DRAIN: begin
               if (r_vld == '0) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!pool_1_en) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Valid/address delay line matching the BRAM read latency, then the
   // registered pooled word. The write address equals the issue index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld   <= '0;
         for (int i = 0; i < READ_LAT; i++) begin
            r_vaddr[i] <= 6'd0;
         end
         r_we    <= 1'b0;
         r_waddr <= 6'd0;
         r_din   <= '0;
      end else if (w_abort) begin
         r_vld <= '0;
         r_we  <= 1'b0;
      end else begin
         r_vld[0]   <= r_ena;
         r_vaddr[0] <= r_cnt;
         for (int i = 1; i < READ_LAT; i++) begin
            r_vld[i]   <= r_vld[i-1];
            r_vaddr[i] <= r_vaddr[i-1];
         end
         r_we <= r_vld[READ_LAT-1];
         if (r_vld[READ_LAT-1]) begin
            r_waddr <= r_vaddr[READ_LAT-1];
            r_din   <= w_pooled;
         end
      end
   end

   // Output lane k pools input lanes 2k and 2k+1 of both rows.
   for (genvar k = 0; k < OUT_LANES; k++) begin : g_lane
      pool_lane #(
         .DATA_W (DATA_W),
         .RELU   (RELU)
      ) u_lane (
         .a0 (fm_bram_1_douta[(2*k)*DATA_W   +: DATA_W]),
         .a1 (fm_bram_1_douta[(2*k+1)*DATA_W +: DATA_W]),
         .b0 (fm_bram_1_doutb[(2*k)*DATA_W   +: DATA_W]),
         .b1 (fm_bram_1_doutb[(2*k+1)*DATA_W +: DATA_W]),
         .y  (w_pooled[k*DATA_W +: DATA_W])
      );
   end

   assign fm_bram_1_ena   = r_ena;
   assign fm_bram_1_enb   = r_ena;
   assign fm_bram_1_addra = r_addra;
   assign fm_bram_1_addrb = r_addrb;
   assign fm_bram_2_we    = r_we;
   assign fm_bram_2_addr  = r_waddr;
   assign fm_bram_2_din   = r_din;
   assign busy            = (r_state == ST_ISSUE) | (r_state == ST_DRAIN);
   assign pool_1_finish   = (r_state == ST_DONE);

endmodule
`default_nettype wire
